opcode_fetch_seq: RTL and testbench

- Front end of the CPU. Fetches opcode, CB-prefix and immediate bytes from the memory bus, and presents the latched opcode to the microcode lookup.
- Reads back the immediate length decoded from the resulting control word.
- Hands a complete instruction (opcode, prefix flag, immediate) to the execute stage over a valid/ready handshake.
- Owns the program counter; PC is reloadable by execute on jumps, calls and interrupts.

---
 rtl/opcode_fetch_seq.sv | 175 +++++++++++++++++
 tb/tb_opcode_fetch_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_fetch_seq.sv
// -----------------------------------------------------------------------------
// opcode_fetch_seq
//
// CPU front end. Fetches an opcode byte (plus an optional CB page byte and up
// to two immediate bytes) from the memory bus, and presents the latched opcode
// to the microcode lookup. It then reads back the immediate length and hands
// the complete instruction to execute over a valid/ready handshake. It also
// owns the program counter, which execute may reload at any time.
//
// Parameters:
//   RESET_PC     PC value after reset
//   CB_OPCODE    prefix byte that selects the CB opcode page
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   mem_req      read request, held until mem_ack (registered)
//   mem_addr     read address (always equal to pc)
//   mem_ack      read accepted, mem_rdata valid in the same cycle
//   mem_rdata    read data byte
//   opcode       latched opcode for the microcode lookup
//   cb_prefix    opcode belongs to the CB-prefixed page
//   imm_len      immediate byte count from the control word (3 acts as 2)
//   imm          immediate, first byte in [7:0], second in [15:8]
//   issue_valid  instruction complete, held until issue_ready
//   issue_ready  execute accepts the instruction
//   pc           address of the next byte to fetch
//   pc_load      redirect request from execute (highest priority)
//   pc_load_val  redirect target
// -----------------------------------------------------------------------------
module opcode_fetch_seq #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [7:0]  CB_OPCODE = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  input  logic [1:0]  imm_len,
  output logic [15:0] imm,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [15:0] pc,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val
);

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_CB,
    LEN,
    FETCH_IMM,
    ISSUE
  } state_t;

  state_t     state;
  logic [1:0] imm_cnt;  // immediate bytes still to fetch
  logic       imm_hi;   // next immediate byte goes to imm[15:8]
  logic       xfer;
  logic [1:0] len_eff;

  // A byte moves only when the request is up and memory accepts it.
  assign xfer     = mem_req & mem_ack;
  assign mem_addr = pc;
  // The control word can encode 3, but no instruction carries more than two
  // immediate bytes.
  assign len_eff  = (imm_len == 2'd3) ? 2'd2 : imm_len;

  // NOTE: all state here updates with non-blocking assignments so every
  // branch sees the pre-edge values of pc, state and mem_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_OP;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      opcode      <= 8'h00;
      cb_prefix   <= 1'b0;
      imm         <= 16'h0000;
      issue_valid <= 1'b0;
      imm_cnt     <= 2'd0;
      imm_hi      <= 1'b0;
    end else if (pc_load) begin
      // Redirect wins over everything: any byte arriving this cycle is
      // dropped and pc does not advance. A concurrent issue handshake has
      // already been seen by execute, so clearing issue_valid is correct.
      pc          <= pc_load_val;
      state       <= FETCH_OP;
      issue_valid <= 1'b0;
      mem_req     <= 1'b1;
    end else begin
      if (xfer) begin
        pc <= pc + 16'd1;
      end

      case (state)
        FETCH_OP: begin
          if (xfer) begin
            opcode    <= mem_rdata;
            cb_prefix <= 1'b0;
            imm       <= 16'h0000;
            if (mem_rdata == CB_OPCODE) begin
              state <= FETCH_CB;      // keep requesting for the page byte
            end else begin
              state   <= LEN;
              mem_req <= 1'b0;
            end
          end else begin
            mem_req <= 1'b1;          // first fetch after reset starts here
          end
        end

        FETCH_CB: begin
          if (xfer) begin
            opcode    <= mem_rdata;
            cb_prefix <= 1'b1;
            state     <= LEN;
            mem_req   <= 1'b0;
          end else begin
            mem_req <= 1'b1;
          end
        end

        LEN: begin
          // opcode/cb_prefix settled last edge, so imm_len is valid now.
          if (len_eff == 2'd0) begin
            state       <= ISSUE;
            issue_valid <= 1'b1;
          end else begin
            imm_cnt <= len_eff;
            imm_hi  <= 1'b0;
            state   <= FETCH_IMM;
            mem_req <= 1'b1;
          end
        end

        FETCH_IMM: begin
          if (xfer) begin
            if (imm_hi) begin
              imm[15:8] <= mem_rdata;
            end else begin
              imm[7:0] <= mem_rdata;
            end
            imm_hi  <= 1'b1;
            imm_cnt <= imm_cnt - 2'd1;
            if (imm_cnt == 2'd1) begin
              state       <= ISSUE;
              mem_req     <= 1'b0;
              issue_valid <= 1'b1;
            end
          end
        end

        ISSUE: begin
          // No prefetch: the bus stays idle until execute takes the
          // instruction, then the next opcode fetch starts immediately.
          if (issue_ready) begin
            issue_valid <= 1'b0;
            state       <= FETCH_OP;
            mem_req     <= 1'b1;
          end
        end

        default: begin
          state   <= FETCH_OP;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_opcode_fetch_seq
//
// Bench for opcode_fetch_seq. A 64 KiB byte array serves the memory bus, and
// the immediate length is decoded from the DUT's opcode/cb_prefix by a small
// stand-in for the microcode ROM. Directed vectors cover the listed fetch
// shapes. Hand-written sequences cover stall, redirect, PC wrap and async
// reset. A randomized run compares every accepted instruction against a
// byte-walk model of the program in memory.
// -----------------------------------------------------------------------------
module tb_opcode_fetch_seq;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic [1:0]  imm_len;
  logic [15:0] imm;
  logic        issue_valid;
  logic        issue_ready;
  logic [15:0] pc;
  logic        pc_load;
  logic [15:0] pc_load_val;

  // Second instance with a top-of-memory reset PC, for the wrap case.
  logic        mem_req2;
  logic [15:0] mem_addr2;
  logic [7:0]  mem_rdata2;
  logic [7:0]  opcode2;
  logic        cb_prefix2;
  logic [1:0]  imm_len2;
  logic [15:0] imm2;
  logic        issue_valid2;
  logic [15:0] pc2;

  logic [7:0] mem [0:65535];
  int         ack_mode;   // 0: always, 1: every 3rd cycle, 2: random
  int         ack_ph;
  int         tests;
  int         failed;

  // Stand-in for the microcode control word's immediate length field.
  function automatic logic [1:0] dec_len(input logic [7:0] op, input logic cb);
    if (cb)                return 2'd0;
    else if (op == 8'hC3)  return 2'd2;
    else                   return op[1:0];
  endfunction

  assign mem_rdata  = mem[mem_addr];
  assign imm_len    = dec_len(opcode, cb_prefix);
  assign mem_rdata2 = mem[mem_addr2];
  assign imm_len2   = dec_len(opcode2, cb_prefix2);

  opcode_fetch_seq dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .opcode(opcode), .cb_prefix(cb_prefix), .imm_len(imm_len), .imm(imm),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .pc(pc), .pc_load(pc_load), .pc_load_val(pc_load_val)
  );

  opcode_fetch_seq #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(1'b1), .mem_rdata(mem_rdata2),
    .opcode(opcode2), .cb_prefix(cb_prefix2), .imm_len(imm_len2), .imm(imm2),
    .issue_valid(issue_valid2), .issue_ready(1'b1),
    .pc(pc2), .pc_load(1'b0), .pc_load_val(16'h0000)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory acknowledge pattern, updated away from the active edge.
  initial begin
    mem_ack = 1'b1;
    ack_ph  = 0;
    forever begin
      @(negedge clk);
      ack_ph = (ack_ph == 2) ? 0 : ack_ph + 1;
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = (ack_ph == 0);
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    pc_load     = 1'b0;
    pc_load_val = 16'h0000;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference: decode the instruction starting at 'addr' straight from memory.
  task automatic model_expect(input logic [15:0] addr, output logic [7:0] e_op,
                              output logic e_cb, output logic [15:0] e_imm,
                              output logic [15:0] e_next);
    logic [15:0] p;
    int          n;
    p     = addr;
    e_imm = 16'h0000;
    if (mem[p] == 8'hCB) begin
      e_op = mem[p + 16'd1];
      e_cb = 1'b1;
      p    = p + 16'd2;
      n    = 0;
    end else begin
      e_op = mem[p];
      e_cb = 1'b0;
      p    = p + 16'd1;
      n    = int'(dec_len(e_op, 1'b0));
      if (n == 3) n = 2;
    end
    if (n >= 1) begin
      e_imm[7:0] = mem[p];
      p = p + 16'd1;
    end
    if (n == 2) begin
      e_imm[15:8] = mem[p];
      p = p + 16'd1;
    end
    e_next = p;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          mode;
    logic [7:0]  exp_op;
    logic        exp_cb;
    logic [15:0] exp_imm;
    logic [15:0] exp_pc;
    int          exp_lat;   // 0: latency not checked
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          lat;
    bit          seen;
    int          since;
    int          n_issued;
    logic [15:0] model_pc;
    logic [7:0]  e_op;
    logic        e_cb;
    logic [15:0] e_imm;
    logic [15:0] e_next;

    tests       = 0;
    failed      = 0;
    ack_mode    = 0;
    issue_ready = 1'b1;
    pc_load     = 1'b0;
    pc_load_val = 16'h0000;
    rst         = 1'b1;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0, 16'h0000, 16'h0001, 3};
    vecs[1] = '{8'hC3, 8'h50, 8'h01, 0, 8'hC3, 1'b0, 16'h0150, 16'h0003, 5};
    vecs[2] = '{8'hCB, 8'h37, 8'h00, 0, 8'h37, 1'b1, 16'h0000, 16'h0002, 4};
    vecs[3] = '{8'h01, 8'hAA, 8'h00, 0, 8'h01, 1'b0, 16'h00AA, 16'h0002, 4};
    vecs[4] = '{8'h03, 8'h11, 8'h22, 0, 8'h03, 1'b0, 16'h2211, 16'h0003, 5};
    vecs[5] = '{8'hC3, 8'h50, 8'h01, 1, 8'hC3, 1'b0, 16'h0150, 16'h0003, 0};
    vecs[6] = '{8'hCB, 8'hC3, 8'h77, 0, 8'hC3, 1'b1, 16'h0000, 16'h0002, 4};

    // ---- reset values, applied asynchronously before any clock edge ----
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_issue_valid", 32'(issue_valid), 32'h0);
    check("rst_pc_wrap_inst", 32'(pc2), 32'hFFFF);

    // ---- directed vectors ----
    for (int v = 0; v < 7; v++) begin
      clear_mem();
      mem[0] = vecs[v].b0;
      mem[1] = vecs[v].b1;
      mem[2] = vecs[v].b2;
      ack_mode    = vecs[v].mode;
      issue_ready = 1'b1;
      do_reset();
      lat  = 0;
      seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
        @(negedge clk);
        lat++;
        if (v == 0 && lat == 1) check("v0_mem_req_rise", 32'(mem_req), 32'h1);
        if (issue_valid) seen = 1;
      end
      check($sformatf("v%0d_issued", v), 32'(seen), 32'h1);
      check($sformatf("v%0d_opcode", v), 32'(opcode), 32'(vecs[v].exp_op));
      check($sformatf("v%0d_cb", v), 32'(cb_prefix), 32'(vecs[v].exp_cb));
      check($sformatf("v%0d_imm", v), 32'(imm), 32'(vecs[v].exp_imm));
      check($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
      if (vecs[v].exp_lat != 0)
        check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
    end
    ack_mode = 0;

    // ---- PC wrap: RESET_PC = FFFF, mem[FFFF] = 00 ----
    clear_mem();
    do_reset();
    repeat (3) @(negedge clk);
    check("wrap_issue_valid", 32'(issue_valid2), 32'h1);
    check("wrap_opcode", 32'(opcode2), 32'h00);
    check("wrap_pc", 32'(pc2), 32'h0000);

    // ---- execute stalls for 5 cycles ----
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01;
    issue_ready = 1'b0;
    do_reset();
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (issue_valid) seen = 1;
    end
    check("stall_issued", 32'(seen), 32'h1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("stall%0d_valid", c), 32'(issue_valid), 32'h1);
      check($sformatf("stall%0d_opcode", c), 32'(opcode), 32'hC3);
      check($sformatf("stall%0d_imm", c), 32'(imm), 32'h0150);
      check($sformatf("stall%0d_no_req", c), 32'(mem_req), 32'h0);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 32'(issue_valid), 32'h0);
    check("stall_release_req", 32'(mem_req), 32'h1);
    check("stall_release_addr", 32'(mem_addr), 32'h0003);

    // ---- redirect during the first immediate transfer ----
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01;
    mem[16'h0038] = 8'h00;
    do_reset();
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0001) seen = 1;
    end
    check("redir_reached_imm", 32'(seen), 32'h1);
    pc_load     = 1'b1;
    pc_load_val = 16'h0038;
    @(negedge clk);
    pc_load = 1'b0;
    check("redir_addr", 32'(mem_addr), 32'h0038);
    check("redir_req", 32'(mem_req), 32'h1);
    check("redir_no_issue", 32'(issue_valid), 32'h0);
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (issue_valid) seen = 1;
    end
    check("redir_issued", 32'(seen), 32'h1);
    check("redir_opcode", 32'(opcode), 32'h00);
    check("redir_imm", 32'(imm), 32'h0000);
    check("redir_pc", 32'(pc), 32'h0039);

    // ---- async reset in the middle of FETCH_IMM ----
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01;
    do_reset();
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0002) seen = 1;
    end
    check("arst_reached_imm", 32'(seen), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'h0);
    check("arst_pc", 32'(pc), 32'h0000);
    check("arst_opcode", 32'(opcode), 32'h00);
    check("arst_cb", 32'(cb_prefix), 32'h0);
    check("arst_imm", 32'(imm), 32'h0000);
    check("arst_issue_valid", 32'(issue_valid), 32'h0);

    // ---- randomized program against the byte-walk model ----
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      mem[i] = (r[3:0] == 4'h0) ? 8'hCB : r[15:8];
    end
    ack_mode = 2;
    @(negedge clk);
    do_reset();
    model_pc = 16'h0000;
    since    = 0;
    n_issued = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      issue_ready = 1'($urandom_range(0, 1));
      pc_load     = ($urandom_range(0, 59) == 0);
      pc_load_val = 16'($urandom);
      if (issue_valid && issue_ready) begin
        model_expect(model_pc, e_op, e_cb, e_imm, e_next);
        check("rand_opcode", 32'(opcode), 32'(e_op));
        check("rand_cb", 32'(cb_prefix), 32'(e_cb));
        check("rand_imm", 32'(imm), 32'(e_imm));
        check("rand_pc", 32'(pc), 32'(e_next));
        model_pc = e_next;
        since    = 0;
        n_issued++;
      end else begin
        since++;
      end
      if (pc_load) model_pc = pc_load_val;
      if (since > 300) begin
        check("rand_timeout", 32'h0, 32'h1);
        break;
      end
    end
    check("rand_progress", 32'(n_issued > 50), 32'h1);
    issue_ready = 1'b1;
    pc_load     = 1'b0;
    ack_mode    = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
